// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port W x 2**AW memory between the processor core (port C)
// and the program loader / debug port (port L). Arbitration is round-robin
// with a registered grant. A bounded-hold guard forces a switch once the
// owner has held the memory for MAX_HOLD consecutive cycles while the other
// port was also requesting. The core stalls while c_gnt is low.
//
// Optional feature, enabled by the macro ARB_WR_PROTECT_EN:
//   A core write to any address >= PROT_BASE is suppressed and sets the
//   sticky prot_err flag. Loader writes are never blocked. When the macro
//   is undefined, PROT_BASE does not exist and prot_err is tied to 0.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   c_req/c_we/c_ad/c_data  core request, write enable, address, write data
//   c_gnt                 core owns the memory this cycle
//   c_rd, c_valid         registered core read data, one-cycle valid pulse
//   l_*                   loader equivalents of the core signals
//   mem_WE/mem_ad/mem_data  memory write enable, address, write data
//   mem_RD                memory read data (combinational from mem_ad)
//   owner                 current state: 00 IDLE, 01 CORE, 10 LOAD
//   prot_err              sticky core write-protection violation
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int W        = 17,
    parameter int AW       = 8,
    parameter int MAX_HOLD = 4
`ifdef ARB_WR_PROTECT_EN
    ,
    parameter logic [AW-1:0] PROT_BASE = 8'hF0
`endif
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_ad,
    input  logic [W-1:0]  c_data,
    output logic          c_gnt,
    output logic [W-1:0]  c_rd,
    output logic          c_valid,

    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_ad,
    input  logic [W-1:0]  l_data,
    output logic          l_gnt,
    output logic [W-1:0]  l_rd,
    output logic          l_valid,

    output logic          mem_WE,
    output logic [AW-1:0] mem_ad,
    output logic [W-1:0]  mem_data,
    input  logic [W-1:0]  mem_RD,

    output logic [1:0]    owner,
    output logic          prot_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CORE = 2'b01,
        S_LOAD = 2'b10
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t       state_q, state_d;
    logic [3:0]   hold_cnt_q, hold_cnt_d;
    logic         last_load_q, last_load_d;   // 1: LOAD was the last owner
    logic [W-1:0] c_rd_q, c_rd_d;
    logic [W-1:0] l_rd_q, l_rd_d;
    logic         c_valid_q, c_valid_d;
    logic         l_valid_q, l_valid_d;

    logic c_access;
    logic l_access;
    logic c_wr_block;

    // Grants decode straight from the registered state.
    assign c_gnt    = (state_q == S_CORE);
    assign l_gnt    = (state_q == S_LOAD);
    assign c_access = c_gnt & c_req;
    assign l_access = l_gnt & l_req;

`ifdef ARB_WR_PROTECT_EN
    logic prot_err_q;

    // The grant is still consumed; only the write strobe is suppressed.
    assign c_wr_block = c_access & c_we & (c_ad >= PROT_BASE);
    assign prot_err   = prot_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prot_err_q <= 1'b0;
        end else if (c_wr_block) begin
            prot_err_q <= 1'b1;
        end
    end
`else
    assign c_wr_block = 1'b0;
    assign prot_err   = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state, hold counter and round-robin history
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default at the top of the block so that no
    // path through the case statement can leave it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = 4'd0;
        last_load_d = last_load_q;

        unique case (state_q)
            S_IDLE: begin
                if (c_req && l_req) begin
                    state_d = last_load_q ? S_CORE : S_LOAD;
                end else if (c_req) begin
                    state_d = S_CORE;
                end else if (l_req) begin
                    state_d = S_LOAD;
                end
            end
            S_CORE: begin
                if (!c_req) begin
                    state_d = l_req ? S_LOAD : S_IDLE;
                end else if (l_req && (hold_cnt_q == HOLD_LAST)) begin
                    state_d = S_LOAD;   // forced hand-over, no idle bubble
                end
            end
            S_LOAD: begin
                if (!l_req) begin
                    state_d = c_req ? S_CORE : S_IDLE;
                end else if (c_req && (hold_cnt_q == HOLD_LAST)) begin
                    state_d = S_CORE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The counter only runs while the current owner is contested; an
        // uncontested owner may hold indefinitely.
        if (state_d == state_q) begin
            if ((state_q == S_CORE && l_req) || (state_q == S_LOAD && c_req)) begin
                hold_cnt_d = hold_cnt_q + 4'd1;
            end
        end

        if (state_d == S_CORE) begin
            last_load_d = 1'b0;
        end else if (state_d == S_LOAD) begin
            last_load_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Memory-side mux and read capture
    // -------------------------------------------------------------------------
    always_comb begin
        mem_ad   = '0;
        mem_data = '0;
        unique case (state_q)
            S_CORE: begin
                mem_ad   = c_ad;
                mem_data = c_data;
            end
            S_LOAD: begin
                mem_ad   = l_ad;
                mem_data = l_data;
            end
            default: ;
        endcase
    end

    assign mem_WE = (c_access & c_we & ~c_wr_block) | (l_access & l_we);

    always_comb begin
        c_valid_d = c_access & ~c_we;
        l_valid_d = l_access & ~l_we;
        c_rd_d    = c_valid_d ? mem_RD : c_rd_q;
        l_rd_d    = l_valid_d ? mem_RD : l_rd_q;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hold_cnt_q  <= 4'd0;
            last_load_q <= 1'b1;        // core wins the first tie
            c_rd_q      <= '0;
            l_rd_q      <= '0;
            c_valid_q   <= 1'b0;
            l_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            last_load_q <= last_load_d;
            c_rd_q      <= c_rd_d;
            l_rd_q      <= l_rd_d;
            c_valid_q   <= c_valid_d;
            l_valid_q   <= l_valid_d;
        end
    end

    assign owner   = state_q;
    assign c_rd    = c_rd_q;
    assign l_rd    = l_rd_q;
    assign c_valid = c_valid_q;
    assign l_valid = l_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with a behavioural 17 x 256 memory.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. A vector table covers single-port reads/writes, hold/release
// and idle transitions; hand-written sequences cover the contested
// round-robin pattern, asynchronous reset during a loader grant and the
// write-protect behaviour (both builds).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, l_req, l_we;
    logic [7:0]  c_ad, l_ad;
    logic [16:0] c_data, l_data;
    logic        c_gnt, c_valid, l_gnt, l_valid;
    logic [16:0] c_rd, l_rd;
    logic        mem_WE;
    logic [7:0]  mem_ad;
    logic [16:0] mem_data, mem_RD;
    logic [1:0]  owner;
    logic        prot_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .c_req    (c_req),
        .c_we     (c_we),
        .c_ad     (c_ad),
        .c_data   (c_data),
        .c_gnt    (c_gnt),
        .c_rd     (c_rd),
        .c_valid  (c_valid),
        .l_req    (l_req),
        .l_we     (l_we),
        .l_ad     (l_ad),
        .l_data   (l_data),
        .l_gnt    (l_gnt),
        .l_rd     (l_rd),
        .l_valid  (l_valid),
        .mem_WE   (mem_WE),
        .mem_ad   (mem_ad),
        .mem_data (mem_data),
        .mem_RD   (mem_RD),
        .owner    (owner),
        .prot_err (prot_err)
    );

    // Behavioural single-port memory with a synchronous preload.
    logic        mem_init;
    logic [16:0] mem [256];

    assign mem_RD = mem[mem_ad];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 17'h0;
            mem[8'h10] <= 17'h1ABCD;
            mem[8'hF4] <= 17'h0DEAD;
        end else if (mem_WE) begin
            mem[mem_ad] <= mem_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input bit loader);
        bit got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (loader ? l_gnt : c_gnt) begin
                got = 1'b1;
                break;
            end
        end
        check(loader ? "wait_l_gnt" : "wait_c_gnt", 32'(got), 32'd1);
    endtask

    typedef struct {
        logic        c_req, c_we;
        logic [7:0]  c_ad;
        logic [16:0] c_data;
        logic        l_req, l_we;
        logic [7:0]  l_ad;
        logic [16:0] l_data;
        logic [1:0]  owner;
        logic        c_gnt, l_gnt, mem_we, c_valid, l_valid;
        logic [16:0] c_rd;
    } vec_t;

    vec_t vecs [15];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] prev_owner;
        logic [1:0] exp_owner;

        // Inputs applied in row i, outputs observed in the same cycle.
        //           c_req we ad     data       l_req we ad     data       own cg lg we cv lv c_rd
        vecs[0]  = '{1'b1,1'b0,8'h10,17'h00000, 1'b0,1'b0,8'h00,17'h00000, 2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,17'h00000};
        vecs[1]  = '{1'b1,1'b0,8'h10,17'h00000, 1'b0,1'b0,8'h00,17'h00000, 2'd1,1'b1,1'b0,1'b0,1'b0,1'b0,17'h00000};
        vecs[2]  = '{1'b0,1'b0,8'h10,17'h00000, 1'b0,1'b0,8'h00,17'h00000, 2'd1,1'b1,1'b0,1'b0,1'b1,1'b0,17'h1ABCD};
        vecs[3]  = '{1'b0,1'b0,8'h00,17'h00000, 1'b1,1'b1,8'h20,17'h00155, 2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,17'h1ABCD};
        vecs[4]  = '{1'b0,1'b0,8'h00,17'h00000, 1'b1,1'b1,8'h20,17'h00155, 2'd2,1'b0,1'b1,1'b1,1'b0,1'b0,17'h1ABCD};
        vecs[5]  = '{1'b1,1'b0,8'h20,17'h00000, 1'b0,1'b0,8'h20,17'h00155, 2'd2,1'b0,1'b1,1'b0,1'b0,1'b0,17'h1ABCD};
        vecs[6]  = '{1'b1,1'b0,8'h20,17'h00000, 1'b0,1'b0,8'h00,17'h00000, 2'd1,1'b1,1'b0,1'b0,1'b0,1'b0,17'h1ABCD};
        vecs[7]  = '{1'b0,1'b0,8'h20,17'h00000, 1'b0,1'b0,8'h00,17'h00000, 2'd1,1'b1,1'b0,1'b0,1'b1,1'b0,17'h00155};
        vecs[8]  = '{1'b1,1'b1,8'h30,17'h0AAAA, 1'b0,1'b0,8'h00,17'h00000, 2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,17'h00155};
        vecs[9]  = '{1'b1,1'b1,8'h30,17'h0AAAA, 1'b0,1'b0,8'h00,17'h00000, 2'd1,1'b1,1'b0,1'b1,1'b0,1'b0,17'h00155};
        vecs[10] = '{1'b0,1'b0,8'h30,17'h00000, 1'b0,1'b0,8'h00,17'h00000, 2'd1,1'b1,1'b0,1'b0,1'b0,1'b0,17'h00155};
        vecs[11] = '{1'b0,1'b0,8'h00,17'h00000, 1'b0,1'b0,8'h00,17'h00000, 2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,17'h00155};
        vecs[12] = '{1'b1,1'b0,8'h30,17'h00000, 1'b0,1'b0,8'h00,17'h00000, 2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,17'h00155};
        vecs[13] = '{1'b1,1'b0,8'h30,17'h00000, 1'b0,1'b0,8'h00,17'h00000, 2'd1,1'b1,1'b0,1'b0,1'b0,1'b0,17'h00155};
        vecs[14] = '{1'b0,1'b0,8'h00,17'h00000, 1'b0,1'b0,8'h00,17'h00000, 2'd1,1'b1,1'b0,1'b0,1'b1,1'b0,17'h0AAAA};

        // ---------------- reset state ----------------
        reset = 1'b1; mem_init = 1'b1;
        c_req = 0; c_we = 0; c_ad = 0; c_data = 0;
        l_req = 0; l_we = 0; l_ad = 0; l_data = 0;
        tick();
        mem_init = 1'b0;
        @(negedge clk);
        check("rst_owner",    32'(owner),    32'd0);
        check("rst_c_gnt",    32'(c_gnt),    32'd0);
        check("rst_l_gnt",    32'(l_gnt),    32'd0);
        check("rst_valids",   32'({c_valid, l_valid}), 32'd0);
        check("rst_c_rd",     32'(c_rd),     32'd0);
        check("rst_l_rd",     32'(l_rd),     32'd0);
        check("rst_prot_err", 32'(prot_err), 32'd0);
        reset = 1'b0;

        // ---------------- vector table ----------------
        for (int i = 0; i < 15; i++) begin
            tick();
            c_req = vecs[i].c_req; c_we = vecs[i].c_we; c_ad = vecs[i].c_ad; c_data = vecs[i].c_data;
            l_req = vecs[i].l_req; l_we = vecs[i].l_we; l_ad = vecs[i].l_ad; l_data = vecs[i].l_data;
            @(negedge clk);
            check($sformatf("v%0d_owner", i),   32'(owner),   32'(vecs[i].owner));
            check($sformatf("v%0d_c_gnt", i),   32'(c_gnt),   32'(vecs[i].c_gnt));
            check($sformatf("v%0d_l_gnt", i),   32'(l_gnt),   32'(vecs[i].l_gnt));
            check($sformatf("v%0d_mem_WE", i),  32'(mem_WE),  32'(vecs[i].mem_we));
            check($sformatf("v%0d_c_valid", i), 32'(c_valid), 32'(vecs[i].c_valid));
            check($sformatf("v%0d_l_valid", i), 32'(l_valid), 32'(vecs[i].l_valid));
            check($sformatf("v%0d_c_rd", i),    32'(c_rd),    32'(vecs[i].c_rd));
        end
        check("mem20_loader_write", 32'(mem[8'h20]), 32'h00155);
        check("mem30_core_write",   32'(mem[8'h30]), 32'h0AAAA);

        // ---------------- async reset clears valid/rd at once ----------------
        #1 reset = 1'b1;
        c_req = 0; l_req = 0;
        #1;
        check("arst_c_valid", 32'(c_valid), 32'd0);
        check("arst_c_rd",    32'(c_rd),    32'd0);
        check("arst_owner",   32'(owner),   32'd0);

        // ---------------- contested round-robin, MAX_HOLD=4 ----------------
        c_req = 1; c_we = 0; c_ad = 8'h20;
        l_req = 1; l_we = 0; l_ad = 8'h10;
        @(negedge clk);
        reset = 1'b0;
        prev_owner = 2'd0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_owner = ((i / 4) % 2 == 0) ? 2'd1 : 2'd2;
            check($sformatf("rr%0d_owner", i),   32'(owner),   32'(exp_owner));
            check($sformatf("rr%0d_c_valid", i), 32'(c_valid), 32'(prev_owner == 2'd1));
            check($sformatf("rr%0d_l_valid", i), 32'(l_valid), 32'(prev_owner == 2'd2));
            if (prev_owner == 2'd1) check($sformatf("rr%0d_c_rd", i), 32'(c_rd), 32'h00155);
            if (prev_owner == 2'd2) check($sformatf("rr%0d_l_rd", i), 32'(l_rd), 32'h1ABCD);
            prev_owner = exp_owner;
        end

        // ---------------- reset in the middle of a LOAD grant ----------------
        #2 reset = 1'b1;
        #1;
        check("midload_owner",   32'(owner),   32'd0);
        check("midload_l_gnt",   32'(l_gnt),   32'd0);
        check("midload_l_valid", 32'(l_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_core_first", 32'(owner), 32'd1);
        check("post_rst_c_gnt",      32'(c_gnt), 32'd1);

        tick();
        c_req = 0; l_req = 0;
        repeat (3) @(negedge clk);
        check("idle_again", 32'(owner), 32'd0);

        // ---------------- core write to the protected window ----------------
        tick();
        c_req = 1; c_we = 1; c_ad = 8'hF4; c_data = 17'h0BEEF;
        wait_gnt(1'b0);
`ifdef ARB_WR_PROTECT_EN
        check("prot_mem_WE", 32'(mem_WE), 32'd0);
`else
        check("prot_mem_WE", 32'(mem_WE), 32'd1);
`endif
        tick();
        c_req = 0; c_we = 0;
        @(negedge clk);
`ifdef ARB_WR_PROTECT_EN
        check("prot_memF4_kept", 32'(mem[8'hF4]), 32'h0DEAD);
        check("prot_err_set",    32'(prot_err),   32'd1);
        repeat (10) @(negedge clk);
        check("prot_err_sticky", 32'(prot_err),   32'd1);
`else
        check("noprot_memF4",    32'(mem[8'hF4]), 32'h0BEEF);
        check("noprot_err",      32'(prot_err),   32'd0);
`endif

        // ---------------- loader write to the same address ----------------
        tick();
        l_req = 1; l_we = 1; l_ad = 8'hF4; l_data = 17'h01111;
        wait_gnt(1'b1);
        check("ld_F4_mem_WE", 32'(mem_WE), 32'd1);
        tick();
        l_req = 0; l_we = 0;
        @(negedge clk);
        check("ld_F4_written", 32'(mem[8'hF4]), 32'h01111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
